// File: rtl/q_reg_pkg.sv
// q_reg_pkg -- shared definitions for the Q register.
//   Q_W          : data width of Q, the ALU bus and the spy bus
//   CNT_W        : width of the consecutive-shift counter
//   q_op_e       : Q operation encodings as carried on {qs1,qs0}
//   sat_inc()    : saturating increment for the shift counter
package q_reg_pkg;

  localparam int Q_W   = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    Q_HOLD = 2'b00,
    Q_SHL  = 2'b01,
    Q_SHR  = 2'b10,
    Q_LOAD = 2'b11
  } q_op_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/q_reg.sv
// q_reg -- the microsequencer Q register with multiply/divide step shifts.
// Ports:
//   clk         in   system clock, rising-edge
//   reset       in   synchronous active-high reset
//   state_fetch in   FETCH phase; Q operations only take effect here
//   qs0, qs1    in   Q operation select, decoded as {qs1,qs0}
//   qdrive      in   gate Q onto the M-function bus
//   alu         in   ALU result (load source and shift-in bit)
//   spy_wr      in   debug write strobe, overrides any operation
//   spy_data    in   debug write data
//   q           out  current Q contents
//   mf_q        out  Q when qdrive=1, else 0
//   shift_cnt   out  consecutive shift count, saturating at 31
//   shift_ovf   out  sticky: a shift was taken while shift_cnt was 31
module q_reg
  import q_reg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             state_fetch,
  input  logic             qs0,
  input  logic             qs1,
  input  logic             qdrive,
  input  logic [Q_W-1:0]   alu,
  input  logic             spy_wr,
  input  logic [Q_W-1:0]   spy_data,
  output logic [Q_W-1:0]   q,
  output logic [Q_W-1:0]   mf_q,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             shift_ovf
);

  logic [Q_W-1:0]   q_reg_r;
  logic [Q_W-1:0]   q_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_reg;
  logic             ovf_next;
  q_op_e            op;

  assign op = q_op_e'({qs1, qs0});

  always_comb begin
    q_next   = q_reg_r;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (spy_wr) begin
      // Debug write wins over everything except reset, including the
      // overflow set of a coincident shift.
      q_next   = spy_data;
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (state_fetch) begin
      unique case (op)
        Q_SHL: begin
          // Divide step shifts in the inverted ALU sign.
          q_next   = {q_reg_r[Q_W-2:0], ~alu[Q_W-1]};
          cnt_next = sat_inc(cnt_reg);
          if (cnt_reg == CNT_MAX) ovf_next = 1'b1;
        end
        Q_SHR: begin
          // Multiply step shifts the ALU low bit into the MSB.
          q_next   = {alu[0], q_reg_r[Q_W-1:1]};
          cnt_next = sat_inc(cnt_reg);
          if (cnt_reg == CNT_MAX) ovf_next = 1'b1;
        end
        Q_LOAD: begin
          q_next   = alu;
          cnt_next = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg_r <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      q_reg_r <= q_next;
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
    end
  end

  assign q         = q_reg_r;
  assign mf_q      = qdrive ? q_reg_r : '0;
  assign shift_cnt = cnt_reg;
  assign shift_ovf = ovf_reg;

endmodule

// File: tb/tb_q_reg.sv
// tb_q_reg -- self-checking bench for q_reg: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_q_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        state_fetch = 1'b0;
  logic        qs0 = 1'b0;
  logic        qs1 = 1'b0;
  logic        qdrive = 1'b0;
  logic [31:0] alu = '0;
  logic        spy_wr = 1'b0;
  logic [31:0] spy_data = '0;
  logic [31:0] q;
  logic [31:0] mf_q;
  logic [4:0]  shift_cnt;
  logic        shift_ovf;

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [31:0] m_q = '0;
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  bit          m_valid = 1'b0;

  q_reg dut (
    .clk(clk), .reset(reset), .state_fetch(state_fetch),
    .qs0(qs0), .qs1(qs1), .qdrive(qdrive), .alu(alu),
    .spy_wr(spy_wr), .spy_data(spy_data), .q(q), .mf_q(mf_q),
    .shift_cnt(shift_cnt), .shift_ovf(shift_ovf)
  );

  always #5 clk = ~clk;

  // Model: the register's rules stated directly in arithmetic.
  always @(posedge clk) begin
    int op;
    op = {qs1, qs0};
    if (reset) begin
      m_q = 0; m_cnt = 0; m_ovf = 0; m_valid = 1;
    end else if (spy_wr) begin
      m_q = spy_data; m_cnt = 0; m_ovf = 0;
    end else if (state_fetch && op != 0) begin
      if (op == 3) begin
        m_q = alu; m_cnt = 0;
      end else begin
        if (op == 1) m_q = (m_q << 1) | {31'd0, ~alu[31]};
        else         m_q = (m_q >> 1) | ({31'd0, alu[0]} << 31);
        if (m_cnt == 31) m_ovf = 1;
        else m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q", q, m_q);
      chk("model_mf_q", mf_q, qdrive ? m_q : 32'd0);
      chk("model_cnt", {27'd0, shift_cnt}, m_cnt);
      chk("model_ovf", {31'd0, shift_ovf}, {31'd0, m_ovf});
    end
  end

  // Drive one cycle's inputs, then wait past the sampling edge.
  task automatic cyc(input bit r, input bit f, input bit [1:0] op, input bit qd,
                     input logic [31:0] a, input bit sw, input logic [31:0] sd);
    reset = r; state_fetch = f; {qs1, qs0} = op; qdrive = qd;
    alu = a; spy_wr = sw; spy_data = sd;
    @(posedge clk); #1;
    $display("txn r=%0b f=%0b op=%0d qd=%0b alu=%08h sw=%0b sd=%08h -> q=%08h cnt=%0d ovf=%0b",
             r, f, op, qd, a, sw, sd, q, shift_cnt, shift_ovf);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    cyc(1, 1, 3, 1, 32'hFFFF_FFFF, 0, 0);
    chk("reset_q", q, 0);
    chk("reset_mf_q", mf_q, 0);
    chk("reset_cnt", {27'd0, shift_cnt}, 0);
    chk("reset_ovf", {31'd0, shift_ovf}, 0);

    cyc(0, 1, 3, 1, 32'h1234_5678, 0, 0);
    chk("load_q", q, 32'h1234_5678);
    chk("load_cnt", {27'd0, shift_cnt}, 0);

    cyc(0, 1, 3, 1, 32'h8000_0001, 0, 0);
    cyc(0, 1, 1, 1, 32'h0000_0000, 0, 0);
    chk("shl_q", q, 32'h0000_0003);
    cyc(0, 1, 2, 1, 32'h0000_0001, 0, 0);
    chk("shr_q", q, 32'h8000_0001);
    chk("shr_cnt", {27'd0, shift_cnt}, 2);

    cyc(0, 0, 3, 1, 32'h0000_FFFF, 0, 0);
    chk("nofetch_q", q, 32'h8000_0001);
    chk("nofetch_cnt", {27'd0, shift_cnt}, 2);
    cyc(0, 1, 0, 0, 32'h0, 0, 0);
    chk("qdrive0_mf_q", mf_q, 0);
    cyc(0, 1, 0, 1, 32'h0, 0, 0);
    chk("qdrive1_mf_q", mf_q, 32'h8000_0001);

    cyc(0, 1, 3, 1, 32'h0, 0, 0);
    for (int i = 1; i <= 33; i++) begin
      cyc(0, 1, ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd2, 1, $urandom, 0, 0);
      if (i == 31) begin
        chk("sat31_cnt", {27'd0, shift_cnt}, 31);
        chk("sat31_ovf", {31'd0, shift_ovf}, 0);
      end
      if (i == 32) begin
        chk("ovf32_ovf", {31'd0, shift_ovf}, 1);
        chk("ovf32_cnt", {27'd0, shift_cnt}, 31);
      end
      if (i == 33) begin
        chk("ovf33_ovf", {31'd0, shift_ovf}, 1);
        chk("ovf33_cnt", {27'd0, shift_cnt}, 31);
      end
    end

    cyc(0, 1, 1, 1, 32'h0, 1, 32'hCAFE_F00D);
    chk("spyshl_q", q, 32'hCAFE_F00D);
    chk("spyshl_cnt", {27'd0, shift_cnt}, 0);
    chk("spyshl_ovf", {31'd0, shift_ovf}, 0);

    cyc(0, 1, 1, 1, 32'h0, 0, 0);
    cyc(0, 1, 3, 1, 32'h0000_0001, 1, 32'hDEAD_BEEF);
    chk("spyload_q", q, 32'hDEAD_BEEF);
    chk("spyload_cnt", {27'd0, shift_cnt}, 0);
    chk("spyload_ovf", {31'd0, shift_ovf}, 0);

    cyc(0, 1, 1, 1, 32'h0, 0, 0);
    cyc(1, 1, 3, 1, 32'h5555_5555, 1, 32'hAAAA_AAAA);
    chk("rstprio_q", q, 0);
    chk("rstprio_cnt", {27'd0, shift_cnt}, 0);
    chk("rstprio_ovf", {31'd0, shift_ovf}, 0);
    cyc(0, 1, 2, 1, 32'hFFFF_FFFE, 0, 0);
    chk("postrst_shr_q", q, 0);
    cyc(0, 1, 1, 1, 32'h7FFF_FFFF, 0, 0);
    chk("postrst_shl_q", q, 1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 49) == 0), $urandom);
      // Long shift runs so saturation and overflow also occur randomly.
      if ($urandom_range(0, 199) == 0)
        for (int j = 0; j < 40; j++)
          cyc(0, 1, ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd2, 1, $urandom, 0, 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
